// File: rtl/mem_pkg.sv
// Shared types and constants for the memory request responder.
package mem_pkg;

    // Request progress: idle, low byte on the bus, high byte on the bus, completion pulse.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } mem_state;

    // Value substituted for bytes that never arrived because of an aborted cycle.
    localparam logic [7:0] MEM_FILL_BYTE = 8'hFF;

endpackage

// File: rtl/mem_timeout.sv
// Per-byte bus wait counter. Clears on state change, counts cycles with the
// bus cycle open and no acknowledge, and flags expiry on the last allowed wait.
module mem_timeout #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic nrst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

    logic [CW-1:0] r_count;

    // Expiry fires during the TIMEOUT_CYCLES-th consecutive wait cycle.
    assign o_expired = i_enable && (r_count == CW'(TIMEOUT_CYCLES - 1));

    // Wait counter: cleared on entry to a new byte, advanced while waiting.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_expired) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/memory_handler.sv
// Responder for the control unit's memory requests. Turns 8/16-bit
// little-endian accesses into byte cycles on an external req/ack bus and
// returns a one-cycle mem_ack with mem_data.
// Optional feature: define MEM_TIMEOUT_EN to abort byte cycles that wait
// TIMEOUT_CYCLES cycles, fill missing bytes with 8'hFF and set sticky bus_err.
// Handshake: rd_req/wr_req are sampled only in IDLE and must be held until
// mem_ack; a bus byte completes on the cycle where bus_cyc and bus_ack are
// both high, and bus_ack outside bus_cyc is ignored.
module memory_handler
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        rd_req,
    input  logic        wr_req,
    input  logic        wide,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic        mem_ack,
    output logic [15:0] mem_data,
    output logic        busy,
    output logic        bus_cyc,
    output logic        bus_we,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_wdata,
    input  logic [7:0]  bus_rdata,
    input  logic        bus_ack,
    output logic        bus_err
);

    mem_state    r_state;
    mem_state    w_next;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;
    logic        r_wide;
    logic        r_we;
    logic [7:0]  r_lo;
    logic [15:0] r_mem_data;
    logic [15:0] w_result;
    logic        w_req;
    logic        w_step;
    logic        w_timeout;
    logic        w_enter_done;

    assign w_req        = rd_req | wr_req;
    assign w_step       = bus_ack | w_timeout;
    assign w_enter_done = (w_next == DONE) && (r_state != DONE);

`ifdef MEM_TIMEOUT_EN
    logic r_bus_err;
    logic w_tmo_clear;
    logic w_tmo_en;

    assign w_tmo_clear = (r_state != w_next);
    assign w_tmo_en    = bus_cyc & ~bus_ack;

    mem_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .nrst     (nrst),
        .i_clear  (w_tmo_clear),
        .i_enable (w_tmo_en),
        .o_expired(w_timeout)
    );

    // Sticky abort flag, cleared only by reset.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_bus_err <= 1'b0;
        end else if (w_timeout) begin
            r_bus_err <= 1'b1;
        end
    end

    assign bus_err = r_bus_err;
`else
    logic [31:0] w_unused_timeout;

    assign w_unused_timeout = 32'(TIMEOUT_CYCLES);
    assign w_timeout        = 1'b0;
    assign bus_err          = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state: a byte finishes on bus_ack or on abort; an abort skips the high byte.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_req) w_next = LO;
            LO:      if (w_step) w_next = (r_wide && !w_timeout) ? HI : DONE;
            HI:      if (w_step) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Final mem_data value, formed on the byte cycle that leads into DONE.
    always_comb begin
        w_result = r_mem_data;
        if (r_state == LO) begin
            if (r_we) begin
                w_result = {(r_wide ? r_wdata[15:8] : 8'h00), r_wdata[7:0]};
            end else begin
                w_result = {(r_wide ? MEM_FILL_BYTE : 8'h00),
                            (w_timeout ? MEM_FILL_BYTE : bus_rdata)};
            end
        end else if (r_state == HI) begin
            if (r_we) begin
                w_result = r_wdata;
            end else begin
                w_result = {(w_timeout ? MEM_FILL_BYTE : bus_rdata), r_lo};
            end
        end
    end

    // Request capture in IDLE; write wins when both requests are present.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_addr  <= 16'h0000;
            r_wdata <= 16'h0000;
            r_wide  <= 1'b0;
            r_we    <= 1'b0;
        end else if ((r_state == IDLE) && w_req) begin
            r_addr  <= addr;
            r_wdata <= wdata;
            r_wide  <= wide;
            r_we    <= wr_req;
        end
    end

    // Low read byte capture and mem_data update on entry to DONE.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_lo       <= 8'h00;
            r_mem_data <= 16'h0000;
        end else begin
            if ((r_state == LO) && bus_ack) begin
                r_lo <= bus_rdata;
            end
            if (w_enter_done) begin
                r_mem_data <= w_result;
            end
        end
    end

    // Bus and status outputs decoded from state and latched request fields.
    always_comb begin
        bus_cyc   = (r_state == LO) || (r_state == HI);
        bus_we    = bus_cyc & r_we;
        bus_addr  = 16'h0000;
        bus_wdata = 8'h00;
        if (r_state == LO) begin
            bus_addr  = r_addr;
            bus_wdata = r_wdata[7:0];
        end else if (r_state == HI) begin
            bus_addr  = r_addr + 16'd1;
            bus_wdata = r_wdata[15:8];
        end
        mem_ack  = (r_state == DONE);
        busy     = (r_state != IDLE);
        mem_data = r_mem_data;
    end

endmodule

// File: tb/tb_memory_handler.sv
// Self-checking bench for memory_handler: directed requests, a bus responder
// with per-byte wait counts, and a scoreboard monitor on mem_ack.
module tb_memory_handler;

    logic        clk;
    logic        nrst;
    logic        rd_req;
    logic        wr_req;
    logic        wide;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        mem_ack;
    logic [15:0] mem_data;
    logic        busy;
    logic        bus_cyc;
    logic        bus_we;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata;
    logic        bus_ack;
    logic        bus_err;

    memory_handler #(
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk      (clk),
        .nrst     (nrst),
        .rd_req   (rd_req),
        .wr_req   (wr_req),
        .wide     (wide),
        .addr     (addr),
        .wdata    (wdata),
        .mem_ack  (mem_ack),
        .mem_data (mem_data),
        .busy     (busy),
        .bus_cyc  (bus_cyc),
        .bus_we   (bus_we),
        .bus_addr (bus_addr),
        .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata),
        .bus_ack  (bus_ack),
        .bus_err  (bus_err)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] cyc_n = 16'd0;
    always @(posedge clk) cyc_n <= cyc_n + 16'd1;

    // Scoreboard state: {expected ack cycle, expected mem_data}
    logic [31:0] exp_q[$];
    logic [24:0] bus_exp_q[$];   // {we, addr, wdata byte}
    logic [7:0]  rd_q[$];
    int          wait_q[$];
    logic [15:0] last_data = 16'h0000;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Bus responder: each byte gets the next wait count, then acks with the next read byte.
    int   cur_wait = 0;
    logic have_cur = 1'b0;
    always @(negedge clk) begin
        if (!nrst || !bus_cyc) begin
            bus_ack   = 1'b0;
            bus_rdata = 8'h00;
            have_cur  = 1'b0;
        end else begin
            if (!have_cur) begin
                cur_wait = (wait_q.size() > 0) ? wait_q.pop_front() : 0;
                have_cur = 1'b1;
            end
            if (cur_wait == 0) begin
                bus_ack   = 1'b1;
                bus_rdata = (rd_q.size() > 0) ? rd_q.pop_front() : 8'h00;
                have_cur  = 1'b0;
                if (bus_exp_q.size() == 0) begin
                    check("bus_unexpected", {7'd0, bus_we, bus_addr, bus_wdata}, 32'hFFFF_FFFF);
                end else begin
                    check("bus_xfer", {7'd0, bus_we, bus_addr, bus_wdata}, {7'd0, bus_exp_q.pop_front()});
                end
            end else begin
                cur_wait  = cur_wait - 1;
                bus_ack   = 1'b0;
                bus_rdata = 8'h00;
                if (bus_exp_q.size() > 0) begin
                    check("bus_wait_stable", {7'd0, bus_we, bus_addr, bus_wdata}, {7'd0, bus_exp_q[0]});
                end
            end
        end
    end

    // Monitor: pops the scoreboard on mem_ack, otherwise checks mem_data holds.
    always @(negedge clk) begin
        if (nrst) begin
            if (mem_ack) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ack", {16'd0, mem_data}, 32'hFFFF_FFFF);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    check("ack_data", {16'd0, mem_data}, {16'd0, e[15:0]});
                    check("ack_cycle", {16'd0, cyc_n}, {16'd0, e[31:16]});
                    last_data = e[15:0];
                end
            end else begin
                check("hold_data", {16'd0, mem_data}, {16'd0, last_data});
            end
        end
    end

    // Driver: present a request, push its expected result, hold it until mem_ack.
    task automatic do_req(input logic rd, input logic wr, input logic wd, input logic [15:0] a,
                          input logic [15:0] wv, input logic [15:0] exp_data, input int lat);
        int n;
        @(negedge clk);
        rd_req = rd;
        wr_req = wr;
        wide   = wd;
        addr   = a;
        wdata  = wv;
        exp_q.push_back({cyc_n + 16'(lat), exp_data});
        n = 0;
        while (n < 300) begin
            @(negedge clk);
            if (mem_ack) break;
            n++;
        end
        if (n >= 300) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout actual=none required=mem_ack");
            exp_q.delete();
        end
        rd_req = 1'b0;
        wr_req = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_mem_ack"}, {31'd0, mem_ack}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_bus_cyc"}, {31'd0, bus_cyc}, 32'd0);
        check({tag, "_bus_we"}, {31'd0, bus_we}, 32'd0);
        check({tag, "_bus_addr"}, {16'd0, bus_addr}, 32'd0);
        check({tag, "_mem_data"}, {16'd0, mem_data}, 32'd0);
        check({tag, "_bus_err"}, {31'd0, bus_err}, 32'd0);
    endtask

    // Watchdog
    initial begin
        #300000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    // Main sequence
    initial begin
        nrst   = 1'b0;
        rd_req = 1'b0;
        wr_req = 1'b0;
        wide   = 1'b0;
        addr   = 16'h0000;
        wdata  = 16'h0000;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        #2 nrst = 1'b1;

        // Narrow read, zero waits
        wait_q.push_back(0);
        rd_q.push_back(8'h5A);
        bus_exp_q.push_back({1'b0, 16'hC000, 8'h00});
        do_req(1'b1, 1'b0, 1'b0, 16'hC000, 16'h0000, 16'h005A, 2);

        // Wide read across the address wrap
        wait_q.push_back(0); wait_q.push_back(0);
        rd_q.push_back(8'h34); rd_q.push_back(8'h12);
        bus_exp_q.push_back({1'b0, 16'hFFFF, 8'h00});
        bus_exp_q.push_back({1'b0, 16'h0000, 8'h00});
        do_req(1'b1, 1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'h1234, 3);

        // Wide write, two waits per byte
        wait_q.push_back(2); wait_q.push_back(2);
        bus_exp_q.push_back({1'b1, 16'h8000, 8'hEF});
        bus_exp_q.push_back({1'b1, 16'h8001, 8'hBE});
        do_req(1'b0, 1'b1, 1'b1, 16'h8000, 16'hBEEF, 16'hBEEF, 7);

        // Read and write together: write only; request still high in DONE is not re-accepted
        wait_q.push_back(0);
        bus_exp_q.push_back({1'b1, 16'h1234, 8'h77});
        do_req(1'b1, 1'b1, 1'b0, 16'h1234, 16'h1177, 16'h0077, 2);
        repeat (4) @(negedge clk);
        check("no_extra_ack_pending", exp_q.size(), 32'd0);
        check("idle_after_write_busy", {31'd0, busy}, 32'd0);

        // Narrow write with wide data: high byte suppressed
        wait_q.push_back(0);
        bus_exp_q.push_back({1'b1, 16'h4000, 8'hCD});
        do_req(1'b0, 1'b1, 1'b0, 16'h4000, 16'hABCD, 16'h00CD, 2);

        // Narrow read with three waits
        wait_q.push_back(3);
        rd_q.push_back(8'h80);
        bus_exp_q.push_back({1'b0, 16'h00FF, 8'h00});
        do_req(1'b1, 1'b0, 1'b0, 16'h00FF, 16'h0000, 16'h0080, 5);

        // Reset while waiting in the high byte
        wait_q.push_back(0); wait_q.push_back(10000);
        rd_q.push_back(8'hAA);
        bus_exp_q.push_back({1'b0, 16'h3000, 8'h00});
        bus_exp_q.push_back({1'b0, 16'h3001, 8'h00});
        @(negedge clk);
        rd_req = 1'b1;
        wide   = 1'b1;
        addr   = 16'h3000;
        wdata  = 16'h0000;
        @(negedge clk);
        @(negedge clk);
        check("hi_bus_cyc", {31'd0, bus_cyc}, 32'd1);
        check("hi_bus_addr", {16'd0, bus_addr}, 32'h0000_3001);
        check("hi_busy", {31'd0, busy}, 32'd1);
        #2 nrst = 1'b0;
        last_data = 16'h0000;
        #1 check_idle_outputs("midreset");
        @(negedge clk);
        rd_req = 1'b0;
        wide   = 1'b0;
        bus_exp_q.delete();
        wait_q.delete();
        rd_q.delete();
        #2 nrst = 1'b1;

        // Normal read after the mid-operation reset
        wait_q.push_back(0);
        rd_q.push_back(8'hC3);
        bus_exp_q.push_back({1'b0, 16'h2000, 8'h00});
        do_req(1'b1, 1'b0, 1'b0, 16'h2000, 16'h0000, 16'h00C3, 2);

`ifdef MEM_TIMEOUT_EN
        // Wide read with no acknowledge: abort after four waits
        wait_q.push_back(10000);
        bus_exp_q.push_back({1'b0, 16'h6000, 8'h00});
        do_req(1'b1, 1'b0, 1'b1, 16'h6000, 16'h0000, 16'hFFFF, 5);
        check("timeout_bus_err", {31'd0, bus_err}, 32'd1);
        bus_exp_q.delete();
        wait_q.delete();
        wait_q.push_back(0);
        rd_q.push_back(8'h11);
        bus_exp_q.push_back({1'b0, 16'h6100, 8'h00});
        do_req(1'b1, 1'b0, 1'b0, 16'h6100, 16'h0000, 16'h0011, 2);
        check("bus_err_sticky", {31'd0, bus_err}, 32'd1);
`else
        check("bus_err_off", {31'd0, bus_err}, 32'd0);
`endif

        repeat (3) @(negedge clk);
        check("final_exp_q_empty", exp_q.size(), 32'd0);
        check("final_bus_q_empty", bus_exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
